hms_bcd_counter: RTL and testbench
==================================

# hms_bcd_counter

Time-of-day counter core for the digital clock: a cascaded BCD seconds (mod-60), minutes (mod-60) and hours (mod-24) chain. It implements the `counter_60` / `counter_24` behaviour as one synchronous block clocked by a single clock. It sits between the tick/prescaler logic and the display/alarm logic. Manual minute/hour setting inputs allow the time to be adjusted without disturbing the seconds.

## Interface
Parameters:
- `TICK_DIV`, default 1: number of enabled clock cycles per one-second advance; legal range 1..65535.

Ports:
- `CP`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising `CP` clears all state.
- `EN`  in  1  count enable; when 1, each cycle counts toward the next second tick.
- `set_min`  in  1  manual minute increment, one step per cycle asserted.
- `set_hour`  in  1  manual hour increment, one step per cycle asserted.
- `Sec`  out  8  seconds, BCD: [7:4] tens 0-5, [3:0] units 0-9.
- `Min`  out  8  minutes, BCD, same format as `Sec`.
- `CntH`  out  4  hours tens digit, 0-2.
- `CntL`  out  4  hours units digit, 0-9 (0-3 when `CntH` = 2).
- `sec_co`  out  1  combinational; 1 when a tick occurs this cycle and `Sec` = 59.
- `min_co`  out  1  combinational; `sec_co` and `Min` = 59.
- `day_co`  out  1  combinational; `min_co` and hours = 23.

## Operation
- Prescaler: a 16-bit counter `pcnt` increments when `EN` = 1.
  - tick = `EN` && (`pcnt` == `TICK_DIV`-1); `pcnt` returns to 0 on a tick.
  - With `TICK_DIV` = 1, every enabled cycle is a tick.
- Seconds: on a tick, the units digit increments.
  - Units 9 wraps to 0 and increments tens.
  - 59 wraps to 00.
- Minutes: increment with the same BCD rules when `sec_co` = 1 (tick at second 59).
- Hours: increment when `min_co` = 1.
  - Units 9 with tens 0/1 becomes tens+1, units 0.
  - 23 wraps to 00.
- Manual set (only with `MANUAL_SET_EN`):
  - `set_min` = 1 adds one minute; 59 wraps to 00 with no hour carry.
  - `set_hour` = 1 adds one hour; 23 wraps to 00.
  - Set works regardless of `EN`; seconds and prescaler are not affected.
- Simultaneous events:
  - `set_min` with a minute carry in the same cycle: minutes advance by exactly one, not two.
  - If that increment wraps 59 to 00, the hour carry is taken (`min_co` semantics apply).
  - `set_hour` with an hour carry: hours advance by exactly one.
- Priority: `reset` first, then set/carry increment, then hold.
- `EN` = 0: prescaler and all digits hold; carries are 0.
- Outputs are always legal BCD; no load path exists, so illegal codes are unreachable.

## Timing
- Reset (`reset` = 0 at a rising edge): `Sec` = 00, `Min` = 00, `CntH` = 0, `CntL` = 0, `pcnt` = 0; `sec_co`/`min_co`/`day_co` read 0 in the following cycle.
- Reset mid-count takes effect at the next rising edge and overrides `EN` and set inputs in that cycle.
- Latency: a tick or set in cycle N is visible on the outputs after edge N+1; the whole chain updates on the same edge (no ripple clocks).
- Carry outputs are combinational from registered state plus `EN`; they are valid in the cycle before the wrap.

## Configuration
- `MANUAL_SET_EN` defined: `set_min`/`set_hour` behave as described above.
- Not defined: the ports remain, their values are ignored, and the counters advance only via ticks.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with `EN` = 1 -> `Sec` = 00, `Min` = 00, `CntH:CntL` = 00.
- Counting: `TICK_DIV` = 1, `EN` = 1 for 60 cycles after reset -> `Sec` = 00, `Min` = 01; `sec_co` high exactly in cycle 60.
- Day rollover: run 86399 ticks -> 23:59:59 with `day_co` = 1 while `EN` = 1; one more tick -> 00:00:00.
- Manual set: at `Min` = 59, pulse `set_min` once -> `Min` = 00, hours unchanged; 24 `set_hour` pulses from 00 -> 00.
- Enable and prescaler: `TICK_DIV` = 4, toggle `EN` -> `Sec` advances once per 4 enabled cycles and holds while `EN` = 0.
- Collision: at `Sec` = 59 with a tick, assert `set_min` at `Min` = 10 -> `Min` = 11, not 12.

Source files
------------

// File: rtl/hms_bcd_counter.sv
// Time-of-day BCD counter: prescaled seconds (mod-60), minutes (mod-60), hours (mod-24).
// Define MANUAL_SET_EN to honour the set_min/set_hour manual-adjust inputs.
module hms_bcd_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic       set_min,
  input  logic       set_hour,
  output logic [7:0] Sec,
  output logic [7:0] Min,
  output logic [3:0] CntH,
  output logic [3:0] CntL,
  output logic       sec_co,
  output logic       min_co,
  output logic       day_co
);

  localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

  logic [15:0] pcnt;
  logic        tick;
  logic        set_m, set_h;

`ifdef MANUAL_SET_EN
  assign set_m = set_min;
  assign set_h = set_hour;
`else
  logic unused_set;
  assign unused_set = set_min ^ set_hour;
  assign set_m      = 1'b0;
  assign set_h      = 1'b0;
`endif

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23)       return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick   = EN && (pcnt == TERM);
  assign sec_co = tick && (Sec == 8'h59);
  assign min_co = sec_co && (Min == 8'h59);
  assign day_co = min_co && ({CntH, CntL} == 8'h23);

  // A set and a carry landing in the same cycle still advance the digit by one.
  always_ff @(posedge CP) begin
    if (!reset) begin
      pcnt <= '0;
      Sec  <= '0;
      Min  <= '0;
      CntH <= '0;
      CntL <= '0;
    end else begin
      if (EN)                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
      if (tick)              Sec  <= inc60(Sec);
      if (sec_co || set_m)   Min  <= inc60(Min);
      if (min_co || set_h)   {CntH, CntL} <= inc24({CntH, CntL});
    end
  end

endmodule

// File: tb/tb_hms_bcd_counter.sv
// Bench for hms_bcd_counter: two instances (TICK_DIV 1 and 4) share stimulus and are
// compared against an integer seconds-of-day model through an expected-result queue.
module tb_hms_bcd_counter;

`ifdef MANUAL_SET_EN
  localparam bit MAN = 1'b1;
`else
  localparam bit MAN = 1'b0;
`endif

  typedef struct {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hrs;
  } exp_t;

  logic       CP = 1'b0;
  logic       reset = 1'b0, en = 1'b0, set_min = 1'b0, set_hour = 1'b0;
  logic [7:0] sec1, min1, sec4, min4;
  logic [3:0] h1, l1, h4, l4;
  logic       sco1, mco1, dco1, sco4, mco4, dco4;

  int   checks = 0, errors = 0;
  int   s1 = 0, p1 = 0, s4 = 0, p4 = 0;
  logic last_dco1;
  exp_t q[$];

  always #5 CP = ~CP;

  hms_bcd_counter #(.TICK_DIV(1)) d1 (
    .CP(CP), .reset(reset), .EN(en), .set_min(set_min), .set_hour(set_hour),
    .Sec(sec1), .Min(min1), .CntH(h1), .CntL(l1),
    .sec_co(sco1), .min_co(mco1), .day_co(dco1));

  hms_bcd_counter #(.TICK_DIV(4)) d4 (
    .CP(CP), .reset(reset), .EN(en), .set_min(set_min), .set_hour(set_hour),
    .Sec(sec4), .Min(min4), .CntH(h4), .CntL(l4),
    .sec_co(sco4), .min_co(mco4), .day_co(dco4));

  function automatic logic [7:0] bcd2(input int v);
    logic [7:0] b;
    b[7:4] = 4'(v / 10);
    b[3:0] = 4'(v % 10);
    return b;
  endfunction

  function automatic exp_t mk(input int s);
    exp_t x;
    x.sec = bcd2(s % 60);
    x.min = bcd2((s / 60) % 60);
    x.hrs = bcd2(s / 3600);
    return x;
  endfunction

  // Model: carries from the pre-edge state, then advance to the post-edge state.
  task automatic mstep(inout int s, inout int p, input int div, input bit r, e, sm, sh,
                       output bit sco, mco, dco);
    int sec, mn, hr;
    bit tk;
    sec = s % 60; mn = (s / 60) % 60; hr = s / 3600;
    tk  = e && (p == div - 1);
    sco = tk && (sec == 59);
    mco = sco && (mn == 59);
    dco = mco && (hr == 23);
    if (!r) begin
      s = 0; p = 0;
    end else begin
      if (e) p = tk ? 0 : p + 1;
      if (tk) sec = (sec + 1) % 60;
      if (sco || (MAN && sm)) mn = (mn + 1) % 60;
      if (mco || (MAN && sh)) hr = (hr + 1) % 24;
      s = hr * 3600 + mn * 60 + sec;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, e, sm, sh, input bit chk_on);
    bit   c1s, c1m, c1d, c4s, c4m, c4d;
    exp_t x;
    @(negedge CP);
    reset = r; en = e; set_min = sm; set_hour = sh;
    mstep(s1, p1, 1, r, e, sm, sh, c1s, c1m, c1d);
    mstep(s4, p4, 4, r, e, sm, sh, c4s, c4m, c4d);
    if (chk_on) begin
      #1;
      last_dco1 = dco1;
      chk("sec_co1", {7'b0, sco1}, {7'b0, c1s});
      chk("min_co1", {7'b0, mco1}, {7'b0, c1m});
      chk("day_co1", {7'b0, dco1}, {7'b0, c1d});
      chk("sec_co4", {7'b0, sco4}, {7'b0, c4s});
      chk("min_co4", {7'b0, mco4}, {7'b0, c4m});
      chk("day_co4", {7'b0, dco4}, {7'b0, c4d});
      q.push_back(mk(s1));
      q.push_back(mk(s4));
    end
    @(posedge CP);
    #1;
    if (chk_on) begin
      x = q.pop_front();
      chk("sec1", sec1, x.sec); chk("min1", min1, x.min); chk("hrs1", {h1, l1}, x.hrs);
      x = q.pop_front();
      chk("sec4", sec4, x.sec); chk("min4", min4, x.min); chk("hrs4", {h4, l4}, x.hrs);
    end
  endtask

  initial begin
    // Reset held two cycles with EN high
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("rst_sec", sec1, 8'h00); chk("rst_min", min1, 8'h00); chk("rst_hrs", {h1, l1}, 8'h00);

    // 60 ticks -> 00:01:00
    for (int i = 0; i < 60; i++) cyc(1, 1, 0, 0, 1);
    chk("c60_sec", sec1, 8'h00); chk("c60_min", min1, 8'h01); chk("c60_sec4", sec4, 8'h15);

    // Manual set
    if (MAN) begin
      for (int i = 0; i < 58; i++) cyc(1, 0, 1, 0, 1);
      chk("set_min59", min1, 8'h59);
      cyc(1, 0, 1, 0, 1);
      chk("set_wrap_min", min1, 8'h00); chk("set_wrap_hrs", {h1, l1}, 8'h00);
      for (int i = 0; i < 24; i++) cyc(1, 0, 0, 1, 1);
      chk("set_hour24", {h1, l1}, 8'h00);
    end else begin
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 1);
      chk("noset_min", min1, 8'h01); chk("noset_hrs", {h1, l1}, 8'h00);
    end

    // Prescaler and enable
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 1);
    chk("pre_sec4", sec4, 8'h02); chk("pre_sec1", sec1, 8'h08);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
    chk("hold_sec4", sec4, 8'h02); chk("hold_sec1", sec1, 8'h08);
    for (int i = 0; i < 12; i++) cyc(1, (i % 3) != 0, 0, 0, 1);

    // Collisions between set and carry
    if (MAN) begin
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 1);
      for (int i = 0; i < 59; i++) cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 1, 0, 1);
      chk("coll_min", min1, 8'h11); chk("coll_sec", sec1, 8'h00);
      for (int i = 0; i < 48; i++) cyc(1, 0, 1, 0, 1);
      for (int i = 0; i < 59; i++) cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 1, 1, 1);
      chk("coll2_min", min1, 8'h00); chk("coll2_hrs", {h1, l1}, 8'h01);
    end

    // Reset overrides EN and set
    cyc(0, 1, 1, 1, 1);
    chk("mid_rst_sec", sec1, 8'h00); chk("mid_rst_min", min1, 8'h00);
    chk("mid_rst_hrs", {h1, l1}, 8'h00);

    // Day rollover: 86399 ticks then one more
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 86398; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("day_sec", sec1, 8'h59); chk("day_min", min1, 8'h59); chk("day_hrs", {h1, l1}, 8'h23);
    cyc(1, 1, 0, 0, 1);
    chk("day_co", {7'b0, last_dco1}, 8'h01);
    chk("roll_sec", sec1, 8'h00); chk("roll_min", min1, 8'h00); chk("roll_hrs", {h1, l1}, 8'h00);
    cyc(1, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
